// File: rtl/multicycle_controller.sv
// Multi-cycle control sequencer for the RV32I subset (R-type, I-type ALU,
// lui, load, store). Steps FETCH/DECODE/EXEC/MEM/WB over one handshaked
// memory port and drives the datapath strobes from the current state and
// the instruction class latched in DECODE.
//
// Ports:
//   clk, rst              clock (rising edge), synchronous active-high reset
//   op, fun               opcode / funct3 from the IR (sampled in DECODE)
//   mem_ready             memory completes the pending request this cycle
//   mem_req, MemWr        memory request (held until mem_ready), write flag
//   PCWr, IRWr            PC <= PC+4 and IR load, both on fetch completion
//   RegWr, MemtoReg       register-file write and its source select
//   ALUBsrc, ALUctr, ExtOp ALU operand-B select, ALU op, immediate format
//   fault                 sticky: 01 illegal opcode, 10 memory timeout
//   state_o               current state for debug
//   instret               retired-instruction count (wraps)
module multicycle_controller #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       fun,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWr,
    output logic             PCWr,
    output logic             IRWr,
    output logic             RegWr,
    output logic             MemtoReg,
    output logic [1:0]       ALUBsrc,
    output logic [3:0]       ALUctr,
    output logic [2:0]       ExtOp,
    output logic [1:0]       fault,
    output logic [2:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        C_NONE, C_R, C_I, C_LUI, C_LOAD, C_STORE
    } cls_t;

    // Counter holds the number of not-ready cycles seen so far; the
    // TIMEOUT-th not-ready cycle is the one that faults, so a ready on that
    // same cycle still wins.
    localparam int             WCW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(TIMEOUT - 1);

    state_t             state_q;
    cls_t               cls_q, cls_d;
    logic [2:0]         fun_q;
    logic [1:0]         fault_q;
    logic [CNT_W-1:0]   instret_q;
    logic [WCW-1:0]     wcnt_q;

    logic [3:0]         exec_alu;
    logic [1:0]         exec_bsrc;
    logic [2:0]         exec_ext;

    always_comb begin
        cls_d = C_NONE;
        case (op)
            7'b0110011: cls_d = C_R;
            7'b0010011: cls_d = C_I;
            7'b0110111: cls_d = C_LUI;
            7'b0000011: cls_d = C_LOAD;
            7'b0100011: cls_d = C_STORE;
            default:    cls_d = C_NONE;
        endcase
    end

    always_comb begin
        exec_alu  = 4'b0000;
        exec_bsrc = 2'b10;
        exec_ext  = 3'b000;
        case (cls_q)
            C_R:     begin exec_alu = {1'b0, fun_q}; exec_bsrc = 2'b00; end
            C_I:     exec_alu = {1'b0, fun_q};
            C_LUI:   begin exec_alu = 4'b1111; exec_ext = 3'b001; end
            C_STORE: exec_ext = 3'b010;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            cls_q     <= C_NONE;
            fun_q     <= 3'b000;
            fault_q   <= 2'b00;
            instret_q <= '0;
            wcnt_q    <= '0;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        wcnt_q  <= '0;
                        state_q <= S_DECODE;
                    end else if (wcnt_q == WLAST) begin
                        fault_q <= 2'b10;
                        state_q <= S_TRAP;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_DECODE: begin
                    cls_q <= cls_d;
                    fun_q <= fun;
                    if (cls_d == C_NONE) begin
                        fault_q <= 2'b01;
                        state_q <= S_TRAP;
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    wcnt_q <= '0;
                    if (cls_q == C_LOAD || cls_q == C_STORE) state_q <= S_MEM;
                    else                                     state_q <= S_WB;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        wcnt_q <= '0;
                        if (cls_q == C_LOAD) begin
                            state_q <= S_WB;
                        end else begin
                            instret_q <= instret_q + 1'b1;
                            state_q   <= S_FETCH;
                        end
                    end else if (wcnt_q == WLAST) begin
                        fault_q <= 2'b10;
                        state_q <= S_TRAP;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                S_WB: begin
                    wcnt_q    <= '0;
                    instret_q <= instret_q + 1'b1;
                    state_q   <= S_FETCH;
                end
                S_TRAP:  state_q <= S_TRAP;
                default: state_q <= S_TRAP;
            endcase
        end
    end

    // Moore strobes; rst masks everything so an in-flight write is dropped
    // in the very cycle reset is raised.
    always_comb begin
        mem_req  = 1'b0;
        MemWr    = 1'b0;
        PCWr     = 1'b0;
        IRWr     = 1'b0;
        RegWr    = 1'b0;
        MemtoReg = 1'b0;
        ALUBsrc  = 2'b00;
        ALUctr   = 4'b0000;
        ExtOp    = 3'b000;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = 1'b1;
                    IRWr    = mem_ready;
                    PCWr    = mem_ready;
                end
                S_EXEC: begin
                    ALUctr  = exec_alu;
                    ALUBsrc = exec_bsrc;
                    ExtOp   = exec_ext;
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    MemWr   = (cls_q == C_STORE);
                    ALUctr  = exec_alu;
                    ALUBsrc = exec_bsrc;
                    ExtOp   = exec_ext;
                end
                S_WB: begin
                    RegWr    = 1'b1;
                    MemtoReg = (cls_q == C_LOAD);
                    ALUctr   = exec_alu;
                end
                default: ;
            endcase
        end
    end

    assign fault   = rst ? 2'b00 : fault_q;
    assign state_o = rst ? 3'd0  : state_q;
    assign instret = rst ? '0    : instret_q;

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
    localparam int TO = 16;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BAD = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  op = '0;
    logic [2:0]  fun = '0;
    logic        mem_ready = 1'b0;
    logic        mem_req, MemWr, PCWr, IRWr, RegWr, MemtoReg;
    logic [1:0]  ALUBsrc, fault;
    logic [3:0]  ALUctr;
    logic [2:0]  ExtOp, state_o;
    logic [31:0] instret;

    multicycle_controller #(.TIMEOUT(TO), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .op(op), .fun(fun), .mem_ready(mem_ready),
        .mem_req(mem_req), .MemWr(MemWr), .PCWr(PCWr), .IRWr(IRWr),
        .RegWr(RegWr), .MemtoReg(MemtoReg), .ALUBsrc(ALUBsrc),
        .ALUctr(ALUctr), .ExtOp(ExtOp), .fault(fault), .state_o(state_o),
        .instret(instret)
    );

    always #5 clk = ~clk;

    wire [19:0] obs = {state_o, mem_req, MemWr, IRWr, PCWr, RegWr, MemtoReg,
                       ALUBsrc, ALUctr, ExtOp, fault};

    // One expected cycle: inputs to drive plus the required outputs.
    typedef struct {
        logic [6:0]  op;
        logic [2:0]  fun;
        logic        rdy;
        logic [2:0]  st;
        logic        req, wr, irwr, pcwr, regwr, m2r;
        logic [1:0]  bsrc;
        logic [3:0]  aluc;
        logic [2:0]  ext;
        logic [1:0]  f;
        logic [31:0] ist;
    } cyc_t;

    cyc_t        plan[$];
    logic [19:0] obs_q[$];
    logic [31:0] ist_q[$];
    logic [31:0] exp_instret;
    logic [1:0]  exp_fault;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [19:0] ev(input cyc_t c);
        return {c.st, c.req, c.wr, c.irwr, c.pcwr, c.regwr, c.m2r,
                c.bsrc, c.aluc, c.ext, c.f};
    endfunction

    // Idle cycle of a given state: junk on op/fun/mem_ready, all strobes 0.
    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c = '{default: 0};
        c.st  = st;
        c.op  = 7'($urandom);
        c.fun = 3'($urandom);
        c.rdy = 1'($urandom);
        c.ist = exp_instret;
        c.f   = exp_fault;
        return c;
    endfunction

    // Reference model: expand one instruction into its cycle-by-cycle plan.
    // fw / mw are not-ready cycles before the fetch / memory completes;
    // TO or more of them ends in a timeout (caller appends TRAP cycles).
    function automatic void add_instr(input logic [6:0] o, input logic [2:0] fn,
                                      input int fw, input int mw);
        cyc_t c;
        logic is_r, is_i, is_lui, is_ld, is_st;
        logic [3:0] aluc;
        logic [1:0] bsrc;
        logic [2:0] ext;
        is_r   = (o == OP_R);
        is_i   = (o == OP_I);
        is_lui = (o == OP_LUI);
        is_ld  = (o == OP_LD);
        is_st  = (o == OP_ST);
        aluc = (is_r || is_i) ? {1'b0, fn} : (is_lui ? 4'b1111 : 4'b0000);
        bsrc = is_r ? 2'b00 : 2'b10;
        ext  = is_st ? 3'b010 : (is_lui ? 3'b001 : 3'b000);

        for (int i = 0; i < fw && i < TO; i++) begin
            c = blank(3'd0); c.rdy = 1'b0; c.req = 1'b1; plan.push_back(c);
        end
        if (fw >= TO) begin exp_fault = 2'b10; return; end
        c = blank(3'd0); c.rdy = 1'b1; c.req = 1'b1; c.irwr = 1'b1; c.pcwr = 1'b1;
        plan.push_back(c);
        c = blank(3'd1); c.op = o; c.fun = fn; plan.push_back(c);
        if (!(is_r || is_i || is_lui || is_ld || is_st)) begin
            exp_fault = 2'b01; return;
        end
        c = blank(3'd2); c.aluc = aluc; c.bsrc = bsrc; c.ext = ext; plan.push_back(c);
        if (is_ld || is_st) begin
            for (int i = 0; i < mw && i < TO; i++) begin
                c = blank(3'd3); c.rdy = 1'b0; c.req = 1'b1; c.wr = is_st;
                c.aluc = aluc; c.bsrc = bsrc; c.ext = ext; plan.push_back(c);
            end
            if (mw >= TO) begin exp_fault = 2'b10; return; end
            c = blank(3'd3); c.rdy = 1'b1; c.req = 1'b1; c.wr = is_st;
            c.aluc = aluc; c.bsrc = bsrc; c.ext = ext; plan.push_back(c);
            if (is_st) begin exp_instret++; return; end
        end
        c = blank(3'd4); c.regwr = 1'b1; c.m2r = is_ld; c.aluc = aluc; plan.push_back(c);
        exp_instret++;
    endfunction

    function automatic void add_trap(input int n);
        for (int i = 0; i < n; i++) plan.push_back(blank(3'd5));
    endfunction

    task automatic do_reset();
        rst = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_instret = '0; exp_fault = 2'b00;
        plan.delete();
    endtask

    task automatic play();
        obs_q.delete(); ist_q.delete();
        foreach (plan[i]) begin
            op = plan[i].op; fun = plan[i].fun; mem_ready = plan[i].rdy;
            @(negedge clk);
            obs_q.push_back(obs); ist_q.push_back(instret);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        cyc_t c;
        rst = 1'b1; mem_ready = 1'b1; op = OP_ST; fun = 3'd5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({obs, instret} !== 52'd0) begin
                n_bad++;
                $display("FAIL reset_hold[%0d]: got ctl=%h ir=%0d, want all 0", i, obs, instret);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0; mem_ready = 1'b0;
        exp_instret = '0; exp_fault = 2'b00;
        c = blank(3'd0); c.req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== ev(c) || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_state: got ctl=%h ir=%0d, want ctl=%h ir=0", obs, instret, ev(c));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_add_store_load();
        do_reset();
        add_instr(OP_R, 3'b000, 0, 0);
        add_instr(OP_LD, 3'b010, 0, 2);
        add_instr(OP_ST, 3'b010, 0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL basic[%0d]: got ctl=%h ir=%0d, want ctl=%h ir=%0d",
                         i, obs_q[i], ist_q[i], ev(plan[i]), plan[i].ist);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        add_instr(OP_LUI, 3'($urandom), 0, 0);
        add_instr(OP_I, 3'b111, 0, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL b2b[%0d]: got ctl=%h ir=%0d, want ctl=%h ir=%0d",
                         i, obs_q[i], ist_q[i], ev(plan[i]), plan[i].ist);
            end
        end
        mem_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (instret !== exp_instret || plan.size() != 8) begin
            n_bad++;
            $display("FAIL b2b_instret: got %0d after %0d cycles, want %0d after 8",
                     instret, plan.size(), exp_instret);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [6:0] ops [5];
        ops[0] = OP_R; ops[1] = OP_I; ops[2] = OP_LUI; ops[3] = OP_LD; ops[4] = OP_ST;
        do_reset();
        for (int k = 0; k < 30; k++)
            add_instr(ops[$urandom_range(4)], 3'($urandom),
                      $urandom_range(3), $urandom_range(4));
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL random[%0d]: got ctl=%h ir=%0d, want ctl=%h ir=%0d",
                         i, obs_q[i], ist_q[i], ev(plan[i]), plan[i].ist);
            end
        end
    endtask

    task automatic test_illegal();
        cyc_t c;
        do_reset();
        add_instr(OP_R, 3'd3, 0, 0);
        add_instr(OP_BAD, 3'($urandom), $urandom_range(2), 0);
        add_trap(20);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL illegal[%0d]: got ctl=%h ir=%0d, want ctl=%h ir=%0d",
                         i, obs_q[i], ist_q[i], ev(plan[i]), plan[i].ist);
            end
        end
        rst = 1'b1; mem_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_instret = '0; exp_fault = 2'b00;
        c = blank(3'd0); c.req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== ev(c) || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL illegal_recover: got ctl=%h ir=%0d, want ctl=%h ir=0", obs, instret, ev(c));
        end
        @(posedge clk); #1;
    endtask

    task automatic test_timeout();
        do_reset();
        add_instr(OP_R, 3'd0, TO, 0);          // fetch never ready
        add_trap(3);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL fetch_timeout[%0d]: got ctl=%h, want ctl=%h", i, obs_q[i], ev(plan[i]));
            end
        end
        do_reset();
        add_instr(OP_R, 3'd4, TO - 1, 0);      // ready on the last allowed cycle
        add_instr(OP_LD, 3'd2, 0, TO - 1);
        add_instr(OP_ST, 3'd2, 0, TO);         // store times out in MEM
        add_trap(3);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL edge_timeout[%0d]: got ctl=%h ir=%0d, want ctl=%h ir=%0d",
                         i, obs_q[i], ist_q[i], ev(plan[i]), plan[i].ist);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        cyc_t c;
        do_reset();
        add_instr(OP_R, 3'd1, 0, 0);
        add_instr(OP_ST, 3'd2, 0, 3);
        void'(plan.pop_back());                // cut before the store completes
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL pre_abort[%0d]: got ctl=%h, want ctl=%h", i, obs_q[i], ev(plan[i]));
            end
        end
        rst = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({obs, instret} !== 52'd0) begin
                n_bad++;
                $display("FAIL abort_hold[%0d]: got ctl=%h ir=%0d, want all 0", i, obs, instret);
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; mem_ready = 1'b0;
        exp_instret = '0; exp_fault = 2'b00;
        plan.delete();
        c = blank(3'd0); c.req = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== ev(c) || instret !== 32'd0) begin
            n_bad++;
            $display("FAIL abort_state: got ctl=%h ir=%0d, want ctl=%h ir=0", obs, instret, ev(c));
        end
        @(posedge clk); #1;
        // counter restarts cleanly after the abandoned store
        do_reset();
        add_instr(OP_I, 3'd6, 1, 0);
        play();
        for (int i = 0; i < plan.size(); i++) begin
            n_cmp++;
            if (obs_q[i] !== ev(plan[i]) || ist_q[i] !== plan[i].ist) begin
                n_bad++;
                $display("FAIL post_abort[%0d]: got ctl=%h ir=%0d, want ctl=%h ir=%0d",
                         i, obs_q[i], ist_q[i], ev(plan[i]), plan[i].ist);
            end
        end
    endtask

    initial begin
        exp_instret = '0;
        exp_fault   = 2'b00;
        test_reset();
        test_add_store_load();
        test_back_to_back();
        test_random();
        test_illegal();
        test_timeout();
        test_reset_mid_mem();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32I subset the core supports: R-type, I-type ALU, lui, load and store.
- Replaces single-cycle decode with an FSM that steps fetch/decode/execute/memory/writeback over a shared, handshaked instruction/data memory port.
- Drives the same datapath controls as the existing decoder (ALUBsrc, ALUctr, MemtoReg, RegWr, MemWr, ExtOp), plus PC/IR write enables, memory request, fault reporting and a retired-instruction counter.

Parameters:
- TIMEOUT, 16, max cycles mem_req may wait for mem_ready before a memory-timeout fault (≥1).
- CNT_W, 32, width of instret counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- op  input  7  opcode field from the IR. Valid from DECODE onward.
- fun  input  3  funct3 field from the IR.
- mem_ready  input  1  memory completes the current request this cycle.
- mem_req  output  1  memory request, held until mem_ready.
- MemWr  output  1  request is a write. Valid only with mem_req.
- PCWr  output  1  PC <= PC+4.
- IRWr  output  1  IR <= memory read data.
- RegWr  output  1  register-file write.
- MemtoReg  output  1  writeback source is memory data.
- ALUBsrc  output  2  2'b10 = immediate, 2'b00 = rs2.
- ALUctr  output  4  ALU operation.
- ExtOp  output  3  immediate format: 000 = I, 010 = S, 001 = U.
- fault  output  2  00 none, 01 illegal opcode, 10 memory timeout. Sticky.
- state_o  output  3  current state, for debug.
- instret  output  CNT_W  retired-instruction count.

Behaviour:
- States and encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
- Outputs are combinational from state and the latched class register (Moore style). All strobes not listed for a state are 0.
- Reset (rst=1 at an edge), from any state, including mid-MEM:
  - state=FETCH, class=none, fault=00, instret=0, wait counter=0.
  - While rst is high, all outputs are forced to 0.
  - A pending memory request is abandoned; no write completes after reset.
- FETCH:
  - mem_req=1, MemWr=0.
  - When mem_ready=1: IRWr=1, PCWr=1 in that same cycle, then go to DECODE.
- DECODE:
  - Classify op: 0110011=R, 0010011=I, 0110111=lui, 0000011=load, 0100011=store.
  - Latch the class and fun into registers.
  - Any other op: fault<=01, go to TRAP. Otherwise go to EXEC.
- EXEC:
  - ALUctr: R/I = {1'b0, fun}; lui = 4'b1111; load/store = 4'b0000.
  - ALUBsrc: 2'b10 for I, lui, load, store; 2'b00 for R.
  - ExtOp: 010 for store, 001 for lui, else 000.
  - Next state: R/I/lui go to WB; load/store go to MEM.
- MEM:
  - mem_req=1, MemWr=1 for store. ALU/ExtOp/ALUBsrc stay at their EXEC values.
  - On mem_ready: load goes to WB; store goes to FETCH and instret increments.
- WB:
  - RegWr=1, MemtoReg=1 for load. ALUctr holds its EXEC value.
  - Go to FETCH; instret increments.
- Wait counter:
  - Clears on entry to FETCH/MEM and on mem_ready; increments each cycle mem_req=1 and mem_ready=0.
  - If it reaches TIMEOUT with mem_ready still 0: fault<=10, go to TRAP.
  - mem_ready arriving in the same cycle the count hits TIMEOUT counts as success; no fault.
- TRAP: all strobes 0; fault holds. Only rst exits.
- instret wraps modulo 2^CNT_W.
- Latency with zero-wait memory:
  - R/I/lui: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - Each memory wait cycle adds 1.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- add (op=0110011, fun=000), mem_ready=1 on every request → states 0,1,2,4,0; ALUctr=0000 and ALUBsrc=00 in EXEC; RegWr=1 only in WB; instret 0→1 after 4 cycles.
- lw (op=0000011) with 2 wait cycles in MEM → mem_req held 3 cycles in MEM; MemtoReg=1 and RegWr=1 in WB; 7 cycles total; instret +1.
- sw (op=0100011) → ExtOp=010, ALUBsrc=10 in EXEC/MEM; MemWr=1 only with mem_req in MEM; RegWr never asserted; back to FETCH after 4 cycles.
- lui (op=0110111) then addi (op=0010011, fun=111) back-to-back → lui: ALUctr=1111, ExtOp=001; addi: ALUctr=0111, ALUBsrc=10; instret=2 after 8 cycles.
- op=1101111 → fault=01 and state=5 after DECODE; strobes stay 0 for 20 cycles; rst restores FETCH, fault=00, instret=0.
- mem_ready held 0 in FETCH → fault=10 after exactly 16 wait cycles. Repeat with mem_ready=1 on the 16th wait cycle → no fault. Assert rst mid-MEM of a sw → no MemWr after reset; state=0.
